uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive path. Recovers 8N1-style serial frames from the `rx` line using a 16x oversampling tick, and presents each received byte on `dout` with a one-cycle `rx_done_tick` strobe. It is the counterpart to the transmit side of the UART module. It shares the baud tick source and the `register` holding stage, which captures `dout` when `rx_done_tick` is high.

Parameters:
D_BIT, 8, number of data bits per frame, LSB first; legal range 5..9.
SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
PAR_EN, 0, 1 = expect one parity bit after data; 0 = no parity bit.
PAR_ODD, 0, parity sense when PAR_EN=1: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
s_tick  input  1  one-clk-wide pulse at 16x baud rate, from the shared baud generator.
rx  input  1  asynchronous serial input; idles high.
dout  output  D_BIT  last received data word.
rx_done_tick  output  1  one-cycle pulse when a frame completes; `dout` is valid in the same cycle.
frame_err  output  1  stop bit sampled low in the last frame.
par_err  output  1  parity mismatch in the last frame; always 0 when PAR_EN=0.
busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Input synchroniser
  - `rx` passes through a 2-FF synchroniser before any use; both flops reset to 1.
  - `rx_s` below is the synchronised signal.
- Reset (`rst`=0)
  - FSM goes to IDLE.
  - Tick counter s=0, bit counter n=0, shift register b=0.
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `par_err`=0, `busy`=0.
- Counters
  - s is 5 bits and increments only on clk edges where `s_tick`=1.
  - s clears on every state transition.
  - n counts received data bits, 0..D_BIT-1.
- FSM states and transitions
  - IDLE: when `rx_s`=0, go to START with s=0. `s_tick` is not required for this transition.
  - START: on a tick with s==7 (mid start bit):
    - `rx_s`=0: go to DATA with s=0, n=0.
    - `rx_s`=1: glitch or false start; return to IDLE with no pulse and no error update.
  - DATA: on a tick with s==15:
    - Shift in: b <= {rx_s, b[D_BIT-1:1]} (LSB first).
    - Parity accumulator p <= p ^ rx_s.
    - If n==D_BIT-1: go to PARITY when PAR_EN=1, otherwise to STOP. Else n <= n+1.
  - PARITY: on a tick with s==15, capture pbit=rx_s, then go to STOP.
  - STOP: on a tick with s==SB_TICK-1, go to IDLE and, in that same cycle:
    - `dout` <= b.
    - `rx_done_tick` = 1.
    - `frame_err` <= ~rx_s.
    - `par_err` <= PAR_EN & (p ^ pbit ^ PAR_ODD).
- Output timing
  - `rx_done_tick` is high for exactly one clk.
  - `dout`, `frame_err` and `par_err` hold their values until the next frame completes.
- Error handling
  - A frame with `frame_err` is still delivered; `dout` is updated and the pulse fires.
  - After a frame error with `rx` held low (break), the FSM re-enters START once it is back in IDLE. Each break therefore produces repeated frames of 0 with `frame_err`=1, which is acceptable.
- `busy` = (state != IDLE), registered.
- Latency: `rx_done_tick` asserts at the tick that completes the stop-bit sample, which is 2 clk after that `rx` value, due to the synchroniser.
- `s_tick` stuck at 0: the FSM holds its state indefinitely, with no timeout.
- Reset mid-frame: the frame is discarded, no pulse is generated, and `dout` returns to 0.
- Parity: p resets to 0 at IDLE→START.
- Data width: with D_BIT<8, the received bits occupy all of `dout`; there is no padding.

Test Plan:
- 0xA5, 8N1, clk/s_tick ratio 4, 16 ticks per bit → one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, `par_err`=0; `busy` low afterwards.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → three pulses with `dout` 0x00, 0xFF, 0x3C in order.
- Low glitch on `rx` lasting 4 ticks while idle → no pulse; FSM back in IDLE by tick 8; `dout` unchanged.
- 0x55 sent with stop bit driven 0 → pulse, `dout`=0x55, `frame_err`=1. Next clean frame 0x12 → `frame_err`=0.
- PAR_EN=1, PAR_ODD=0, 0x07 with parity bit 1 → `par_err`=0. Repeat with parity bit 0 → `par_err`=1.
- `rst` asserted low during the DATA state of frame 0xC3 → outputs 0 immediately and no pulse. After release, a frame 0x81 → `dout`=0x81.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial input, tick and received-word signals of uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
  parameter int D_BIT = 8
);
  logic             s_tick;
  logic             rx;
  logic [D_BIT-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;
  logic             par_err;
  logic             busy;

  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, par_err, busy
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, par_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampled UART receiver, optional parity, framing check.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  wire logic  clk,
  input  wire logic  rst,
  uart_rx_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [4:0] C_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [3:0] C_N_LAST    = 4'(D_BIT - 1);
  localparam logic       C_PAR_ON    = (PAR_EN != 0);
  localparam logic       C_PAR_ODD   = (PAR_ODD != 0);

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [4:0]       s_q;
  logic [3:0]       n_q;
  logic [D_BIT-1:0] b_q;
  logic             p_q;
  logic             pbit_q;
  logic [D_BIT-1:0] dout_q;
  logic             done_q;
  logic             ferr_q;
  logic             perr_q;
  logic             busy_q;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      pbit_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
            p_q     <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_q == 5'd7) begin
              s_q <= '0;
              // A high line at mid start bit was only a glitch.
              if (!rx_s) begin
                state_q <= DATA;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_q == 5'd15) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[D_BIT-1:1]};
              p_q <= p_q ^ rx_s;
              if (n_q == C_N_LAST) begin
                state_q <= C_PAR_ON ? PARITY : STOP;
              end else begin
                n_q <= n_q + 4'd1;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        PARITY: begin
          if (bus.s_tick) begin
            if (s_q == 5'd15) begin
              s_q     <= '0;
              pbit_q  <= rx_s;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s_q == C_STOP_LAST) begin
              s_q     <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              dout_q  <= b_q;
              done_q  <= 1'b1;
              ferr_q  <= ~rx_s;
              perr_q  <= C_PAR_ON & (p_q ^ pbit_q ^ C_PAR_ODD);
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.par_err      = perr_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed frames into an 8N1 receiver and an even-parity one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic clk;
  logic rst;
  logic s_tick;
  logic rx0;
  logic rx1;

  int n_tests;
  int n_fail;
  int n_done0;
  int n_done1;
  logic [7:0] q0[$];

  uart_rx_if #(.D_BIT(8)) bus0 ();
  uart_rx_if #(.D_BIT(8)) bus1 ();

  assign bus0.s_tick = s_tick;
  assign bus1.s_tick = s_tick;
  assign bus0.rx     = rx0;
  assign bus1.rx     = rx1;

  uart_rx #(.D_BIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  uart_rx #(.D_BIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One s_tick every fourth clock, changed on the falling edge.
  initial begin
    int tcnt;
    tcnt   = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt   = tcnt + 1;
      s_tick = ((tcnt % 4) == 0);
    end
  end

  always @(negedge clk) begin
    if (bus0.rx_done_tick === 1'b1) begin
      n_done0 = n_done0 + 1;
      q0.push_back(bus0.dout);
    end
    if (bus1.rx_done_tick === 1'b1) begin
      n_done1 = n_done1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input bit par_on,
                            input bit pbit, input bit stop_v, input int stop_ticks);
    set_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, data[i]);
      wait_ticks(16);
    end
    if (par_on) begin
      set_rx(sel, pbit);
      wait_ticks(16);
    end
    set_rx(sel, stop_v);
    wait_ticks(stop_ticks);
    set_rx(sel, 1'b1);
  endtask

  initial begin
    int base;
    logic [7:0] v;
    n_tests = 0;
    n_fail  = 0;
    n_done0 = 0;
    n_done1 = 0;
    rst     = 1'b1;
    rx0     = 1'b1;
    rx1     = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dout",  32'(bus0.dout), 32'h0);
    check("rst_done",  32'(bus0.rx_done_tick), 32'h0);
    check("rst_ferr",  32'(bus0.frame_err), 32'h0);
    check("rst_perr",  32'(bus0.par_err), 32'h0);
    check("rst_busy",  32'(bus0.busy), 32'h0);
    rst = 1'b1;
    wait_ticks(4);

    // Single 8N1 frame
    base = n_done0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 16);
    wait_ticks(20);
    check("a5_pulses", 32'(n_done0 - base), 32'd1);
    check("a5_dout",   32'(bus0.dout), 32'hA5);
    check("a5_ferr",   32'(bus0.frame_err), 32'h0);
    check("a5_perr",   32'(bus0.par_err), 32'h0);
    check("a5_busy",   32'(bus0.busy), 32'h0);

    // Back-to-back frames, no idle gap
    q0.delete();
    base = n_done0;
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 16);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 16);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16);
    wait_ticks(20);
    check("b2b_pulses", 32'(n_done0 - base), 32'd3);
    v = (q0.size() > 0) ? q0.pop_front() : 8'hEE;
    check("b2b_0", 32'(v), 32'h00);
    v = (q0.size() > 0) ? q0.pop_front() : 8'hEE;
    check("b2b_1", 32'(v), 32'hFF);
    v = (q0.size() > 0) ? q0.pop_front() : 8'hEE;
    check("b2b_2", 32'(v), 32'h3C);

    // Short low glitch while idle
    base = n_done0;
    set_rx(0, 1'b0);
    wait_ticks(2);
    check("glitch_busy_hi", 32'(bus0.busy), 32'h1);
    wait_ticks(2);
    set_rx(0, 1'b1);
    wait_ticks(8);
    check("glitch_busy_lo", 32'(bus0.busy), 32'h0);
    check("glitch_pulses",  32'(n_done0 - base), 32'd0);
    check("glitch_dout",    32'(bus0.dout), 32'h3C);

    // Stop bit low, then a clean frame clears frame_err
    base = n_done0;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 12);
    wait_ticks(24);
    check("ferr_pulses", 32'(n_done0 - base), 32'd1);
    check("ferr_dout",   32'(bus0.dout), 32'h55);
    check("ferr_set",    32'(bus0.frame_err), 32'h1);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 16);
    wait_ticks(20);
    check("ferr_dout2",  32'(bus0.dout), 32'h12);
    check("ferr_clear",  32'(bus0.frame_err), 32'h0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    base = n_done1;
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 16);
    wait_ticks(20);
    check("par_ok_pulses", 32'(n_done1 - base), 32'd1);
    check("par_ok_dout",   32'(bus1.dout), 32'h07);
    check("par_ok_perr",   32'(bus1.par_err), 32'h0);
    check("par_ok_ferr",   32'(bus1.frame_err), 32'h0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 16);
    wait_ticks(20);
    check("par_bad_pulses", 32'(n_done1 - base), 32'd2);
    check("par_bad_perr",   32'(bus1.par_err), 32'h1);
    check("nopar_perr",     32'(bus0.par_err), 32'h0);

    // Reset in the middle of the data bits
    base = n_done0;
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 16);
      begin
        wait_ticks(64);
        rst = 1'b0;
        #1;
        check("mid_rst_dout", 32'(bus0.dout), 32'h0);
        check("mid_rst_busy", 32'(bus0.busy), 32'h0);
        check("mid_rst_ferr", 32'(bus0.frame_err), 32'h0);
      end
    join
    wait_ticks(4);
    check("mid_rst_pulses", 32'(n_done0 - base), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 16);
    wait_ticks(20);
    check("post_rst_pulses", 32'(n_done0 - base), 32'd1);
    check("post_rst_dout",   32'(bus0.dout), 32'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
